// File: rtl/rsa_key_generator.sv
// RSA key stage: n=p*q, phi=(p-1)(q-1), smallest odd e coprime to phi, d=e^-1 mod phi via
// iterative extended Euclid. Optional self-check of e*d mod phi under macro RSA_KEYGEN_VERIFY_EN.
module rsa_key_generator #(
  parameter int E_START = 3,
  parameter int E_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  firstPrimeNumber,
  input  logic [7:0]  secondPrimeNumber,
  output logic [15:0] n,
  output logic [7:0]  encryptionKey,
  output logic [15:0] decryptionKey,
  output logic        busy,
  output logic        finish,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_EINIT  = 3'd2,
    S_EUCLID = 3'd3,
    S_FIX    = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [8:0] E_START_V = 9'(E_START);
  localparam logic [9:0] E_MAX_V   = 10'(E_MAX);

  state_t             state_r;
  logic [7:0]         p_r;
  logic [7:0]         q_r;
  logic [15:0]        phi_r;
  logic [8:0]         e_r;
  logic [15:0]        r0_r;
  logic [15:0]        r1_r;
  logic signed [17:0] t0_r;
  logic signed [17:0] t1_r;

  logic [15:0]        n_s;
  logic [15:0]        phi_s;
  logic               setup_bad_s;
  logic [15:0]        divisor_s;
  logic [15:0]        quot_s;
  logic [15:0]        rem_s;
  logic signed [17:0] t_next_s;
  logic signed [17:0] d_fix_s;
  logic [9:0]         e_next_s;
`ifdef RSA_KEYGEN_VERIFY_EN
  logic [23:0]        prod_s;
  logic [23:0]        mod_s;
  logic               verify_ok_s;
`endif

  // One Euclid quotient step plus setup arithmetic; divisor forced nonzero so the divider is always defined
  always_comb begin
    n_s         = {8'd0, p_r} * {8'd0, q_r};
    phi_s       = ({8'd0, p_r} - 16'd1) * ({8'd0, q_r} - 16'd1);
    setup_bad_s = (p_r < 8'd3) || (q_r < 8'd3) || (p_r == q_r);
    divisor_s   = (r1_r == 16'd0) ? 16'd1 : r1_r;
    quot_s      = r0_r / divisor_s;
    rem_s       = r0_r % divisor_s;
    // Exact result always fits in 18 signed bits, so truncating the product is harmless
    t_next_s    = t0_r - ($signed({2'b00, quot_s}) * t1_r);
    d_fix_s     = t0_r[17] ? (t0_r + $signed({2'b00, phi_r})) : t0_r;
    e_next_s    = {1'b0, e_r} + 10'd2;
`ifdef RSA_KEYGEN_VERIFY_EN
    prod_s      = {16'd0, encryptionKey} * {8'd0, decryptionKey};
    mod_s       = (phi_r == 16'd0) ? 24'd0 : (prod_s % {8'd0, phi_r});
    verify_ok_s = (mod_s == 24'd1);
`endif
  end

  // Key-generation FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      p_r           <= 8'd0;
      q_r           <= 8'd0;
      phi_r         <= 16'd0;
      e_r           <= 9'd0;
      r0_r          <= 16'd0;
      r1_r          <= 16'd0;
      t0_r          <= 18'sd0;
      t1_r          <= 18'sd0;
      n             <= 16'd0;
      encryptionKey <= 8'd0;
      decryptionKey <= 16'd0;
      busy          <= 1'b0;
      finish        <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          finish <= 1'b0;
          if (start) begin
            p_r     <= firstPrimeNumber;
            q_r     <= secondPrimeNumber;
            error   <= 1'b0;
            busy    <= 1'b1;
            state_r <= S_SETUP;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SETUP: begin
          n     <= n_s;
          phi_r <= phi_s;
          if (setup_bad_s) begin
            error         <= 1'b1;
            encryptionKey <= 8'd0;
            decryptionKey <= 16'd0;
            finish        <= 1'b1;
            busy          <= 1'b0;
            state_r       <= S_DONE;
          end else begin
            e_r     <= E_START_V;
            state_r <= S_EINIT;
          end
        end
        S_EINIT: begin
          r0_r <= phi_r;
          r1_r <= {7'd0, e_r};
          t0_r <= 18'sd0;
          t1_r <= 18'sd1;
          if ({7'd0, e_r} >= phi_r) begin
            error         <= 1'b1;
            encryptionKey <= 8'd0;
            decryptionKey <= 16'd0;
            finish        <= 1'b1;
            busy          <= 1'b0;
            state_r       <= S_DONE;
          end else begin
            state_r <= S_EUCLID;
          end
        end
        S_EUCLID: begin
          if (r1_r != 16'd0) begin
            r0_r    <= r1_r;
            r1_r    <= rem_s;
            t0_r    <= t1_r;
            t1_r    <= t_next_s;
            state_r <= S_EUCLID;
          end else if (r0_r == 16'd1) begin
            state_r <= S_FIX;
          end else if (e_next_s > E_MAX_V) begin
            error         <= 1'b1;
            encryptionKey <= 8'd0;
            decryptionKey <= 16'd0;
            finish        <= 1'b1;
            busy          <= 1'b0;
            state_r       <= S_DONE;
          end else begin
            e_r     <= e_next_s[8:0];
            state_r <= S_EINIT;
          end
        end
        S_FIX: begin
          encryptionKey <= e_r[7:0];
          decryptionKey <= d_fix_s[15:0];
`ifdef RSA_KEYGEN_VERIFY_EN
          state_r       <= S_CHECK;
`else
          finish        <= 1'b1;
          busy          <= 1'b0;
          state_r       <= S_DONE;
`endif
        end
`ifdef RSA_KEYGEN_VERIFY_EN
        S_CHECK: begin
          if (!verify_ok_s) begin
            error         <= 1'b1;
            encryptionKey <= 8'd0;
            decryptionKey <= 16'd0;
          end else begin
            error         <= error;
          end
          finish  <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_DONE;
        end
`endif
        S_DONE: begin
          finish  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          finish  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_key_generator.sv
// Directed-vector bench for rsa_key_generator: hand-computed keys, latencies, error and control cases.
module tb_rsa_key_generator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  firstPrimeNumber;
  logic [7:0]  secondPrimeNumber;
  logic [15:0] n;
  logic [7:0]  encryptionKey;
  logic [15:0] decryptionKey;
  logic        busy;
  logic        finish;
  logic        error;

  int n_vec;
  int n_err;

`ifdef RSA_KEYGEN_VERIFY_EN
  localparam int VERIFY_EXTRA = 1;
`else
  localparam int VERIFY_EXTRA = 0;
`endif

  rsa_key_generator #(.E_START(3), .E_MAX(255)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .firstPrimeNumber  (firstPrimeNumber),
    .secondPrimeNumber (secondPrimeNumber),
    .n                 (n),
    .encryptionKey     (encryptionKey),
    .decryptionKey     (decryptionKey),
    .busy              (busy),
    .finish            (finish),
    .error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".n"}, 32'(n), 32'd0);
    check({tag, ".e"}, 32'(encryptionKey), 32'd0);
    check({tag, ".d"}, 32'(decryptionKey), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".finish"}, 32'(finish), 32'd0);
    check({tag, ".error"}, 32'(error), 32'd0);
  endtask

  // lat counts rising edges from the accepting edge (1) to the edge that raises finish
  task automatic run_case(input string tag, input int p, input int q, input int exp_n,
                          input int exp_e, input int exp_d, input int exp_err,
                          input int exp_lat, input bit repulse);
    int cyc;
    int lat;
    @(negedge clk);
    firstPrimeNumber  = 8'(p);
    secondPrimeNumber = 8'(q);
    start             = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    while (!finish && cyc < 5000) begin
      if (repulse && cyc == 5) begin
        firstPrimeNumber = 8'd67;
        start            = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    lat   = exp_lat + ((exp_err == 0) ? VERIFY_EXTRA : 0);
    check({tag, ".finish"}, 32'(finish), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".n"}, 32'(n), 32'(exp_n));
    check({tag, ".e"}, 32'(encryptionKey), 32'(exp_e));
    check({tag, ".d"}, 32'(decryptionKey), 32'(exp_d));
    check({tag, ".error"}, 32'(error), 32'(exp_err));
    check({tag, ".busy_at_finish"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".finish_pulse"}, 32'(finish), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold_n"}, 32'(n), 32'(exp_n));
    check({tag, ".hold_e"}, 32'(encryptionKey), 32'(exp_e));
    check({tag, ".hold_err"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    int fin_cnt;
    n_vec             = 0;
    n_err             = 0;
    rst_n             = 1'b0;
    start             = 1'b0;
    firstPrimeNumber  = 8'd0;
    secondPrimeNumber = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_case("p67q53", 67, 53, 3551, 5, 1373, 0, 11, 1'b0);
    run_case("p61q53", 61, 53, 3233, 7, 1783, 0, 15, 1'b0);
    run_case("p3q5", 3, 5, 15, 3, 3, 0, 8, 1'b0);
    run_case("p67q67", 67, 67, 4489, 0, 0, 1, 2, 1'b0);
    run_case("p2q53", 2, 53, 106, 0, 0, 1, 2, 1'b0);
    run_case("repulse", 61, 53, 3233, 7, 1783, 0, 15, 1'b1);

    // Abort a 67/53 run partway through the e=5 Euclid steps
    @(negedge clk);
    firstPrimeNumber  = 8'd67;
    secondPrimeNumber = 8'd53;
    start             = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("midreset");
    fin_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finish) fin_cnt++;
    end
    check("midreset.no_finish", 32'(fin_cnt), 32'd0);
    check("midreset.idle_busy", 32'(busy), 32'd0);
    run_case("after_reset", 3, 5, 15, 3, 3, 0, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
